// File: rtl/apac_keypad_entry_pkg.sv
// Shared constants and types for the parking access keypad path.
// Key codes and state encodings are common to entry and access FSMs.
package apac_keypad_entry_pkg;

  localparam int DEF_DIGIT_W     = 4;
  localparam int DEF_N_DIGITS    = 2;
  localparam int DEF_PW_W        = DEF_DIGIT_W * DEF_N_DIGITS;
  localparam int DEF_TIMEOUT_CYC = 64;
  localparam int DEF_TMR_W       = 7;

  localparam logic [3:0] KEY_MAX_DIGIT = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SUBMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/apac_entry_timer.sv
// Inactivity timer for keypad entry.
// Saturating up-counter; expired is high for the one enabled cycle at TIMEOUT_CYC-1.
module apac_entry_timer
  import apac_keypad_entry_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TMR_W       = DEF_TMR_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && cnt_q != TMR_W'(TIMEOUT_CYC)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == TMR_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apac_keypad_entry.sv
// Keypad entry stage: collects digits while a car waits and
// hands a completed password to the access FSM with a one-cycle strobe.
module apac_keypad_entry
  import apac_keypad_entry_pkg::*;
#(
  parameter int DIGIT_W     = DEF_DIGIT_W,
  parameter int N_DIGITS    = DEF_N_DIGITS,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int TMR_W       = DEF_TMR_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sensor_1,
  input  logic                           key_valid,
  input  logic [DIGIT_W-1:0]             key_code,
  output logic [DIGIT_W*N_DIGITS-1:0]    psswrd_atmpt,
  output logic                           try_psswrd,
  output logic                           entry_busy,
  output logic [$clog2(N_DIGITS+1)-1:0]  digit_count,
  output logic                           entry_err
);

  localparam int PW_W  = DIGIT_W * N_DIGITS;
  localparam int CNT_W = $clog2(N_DIGITS + 1);

  state_t           state, state_n;
  logic [PW_W-1:0]  shift_q, shift_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             err_n;
  logic             pw_load;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_expired;
  logic             key_digit;
  logic             key_clear;
  logic             key_enter;
  logic             cnt_full;

  assign key_digit = key_valid && (key_code <= DIGIT_W'(KEY_MAX_DIGIT));
  assign key_clear = key_valid && (key_code == DIGIT_W'(KEY_CLEAR));
  assign key_enter = key_valid && (key_code == DIGIT_W'(KEY_ENTER));
  assign cnt_full  = (cnt_q == CNT_W'(N_DIGITS));
  assign tmr_en    = (state == ST_COLLECT);

  apac_entry_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    cnt_n     = cnt_q;
    err_n     = 1'b0;
    pw_load   = 1'b0;
    tmr_clear = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (sensor_1) begin
          state_n = ST_COLLECT;
          shift_n = '0;
          cnt_n   = '0;
        end
      end
      ST_COLLECT: begin
        tmr_clear = 1'b0;
        // Losing the car outranks any key on the same edge.
        if (!sensor_1) begin
          state_n   = ST_IDLE;
          shift_n   = '0;
          cnt_n     = '0;
          tmr_clear = 1'b1;
        end else begin
          unique case (1'b1)
            key_digit: begin
              tmr_clear = 1'b1;
              if (!cnt_full) begin
                shift_n = {shift_q[PW_W-DIGIT_W-1:0], key_code};
                cnt_n   = cnt_q + 1'b1;
              end else begin
                err_n = 1'b1;
              end
            end
            key_clear: begin
              tmr_clear = 1'b1;
              shift_n   = '0;
              cnt_n     = '0;
            end
            key_enter: begin
              tmr_clear = 1'b1;
              shift_n   = '0;
              cnt_n     = '0;
              if (cnt_full) begin
                pw_load = 1'b1;
                state_n = ST_SUBMIT;
              end else begin
                err_n = 1'b1;
              end
            end
            default: begin
              if (tmr_expired) begin
                tmr_clear = 1'b1;
                shift_n   = '0;
                cnt_n     = '0;
              end
            end
          endcase
        end
      end
      ST_SUBMIT: begin
        state_n = sensor_1 ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      psswrd_atmpt <= '0;
      try_psswrd   <= 1'b0;
      entry_busy   <= 1'b0;
      entry_err    <= 1'b0;
    end else begin
      state      <= state_n;
      shift_q    <= shift_n;
      cnt_q      <= cnt_n;
      try_psswrd <= (state == ST_SUBMIT);
      entry_busy <= (state_n != ST_IDLE);
      entry_err  <= err_n;
      if (pw_load) begin
        psswrd_atmpt <= shift_q;
      end
    end
  end

  assign digit_count = cnt_q;

endmodule

// File: tb/tb_apac_keypad_entry.sv
// Directed bench for apac_keypad_entry: a vector table for the
// single-edge behaviour plus sequences for timeout and async reset.
module tb_apac_keypad_entry;

  typedef struct {
    logic       s;
    logic       kv;
    logic [3:0] code;
    logic [7:0] pw;
    logic       tr;
    logic       busy;
    logic [1:0] cnt;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sensor_1;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] psswrd_atmpt;
  logic       try_psswrd;
  logic       entry_busy;
  logic [1:0] digit_count;
  logic       entry_err;

  int   tests = 0;
  int   fails = 0;
  vec_t vq[$];

  apac_keypad_entry dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_1     (sensor_1),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .psswrd_atmpt (psswrd_atmpt),
    .try_psswrd   (try_psswrd),
    .entry_busy   (entry_busy),
    .digit_count  (digit_count),
    .entry_err    (entry_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic s, input logic kv, input logic [3:0] c,
                     input logic [7:0] pw, input logic tr, input logic bz,
                     input logic [1:0] ct, input logic er);
    vec_t v;
    v = '{s, kv, c, pw, tr, bz, ct, er};
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic kv, input logic [3:0] c);
    sensor_1  = s;
    key_valid = kv;
    key_code  = c;
  endtask

  task automatic check(input string name, input logic [7:0] pw,
                       input logic tr, input logic bz,
                       input logic [1:0] ct, input logic er);
    tests++;
    if ({psswrd_atmpt, try_psswrd, entry_busy, digit_count, entry_err}
        !== {pw, tr, bz, ct, er}) begin
      fails++;
      $display("FAIL %s: got pw=%h try=%b busy=%b cnt=%0d err=%b, want pw=%h try=%b busy=%b cnt=%0d err=%b",
               name, psswrd_atmpt, try_psswrd, entry_busy, digit_count,
               entry_err, pw, tr, bz, ct, er);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0);

    // s kv code | pw try busy cnt err
    add(0, 0, 4'h0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 4'h5, 8'h00, 0, 0, 0, 0);
    add(1, 0, 4'h0, 8'h00, 0, 1, 0, 0);
    add(1, 1, 4'h5, 8'h00, 0, 1, 1, 0);
    add(1, 1, 4'h7, 8'h00, 0, 1, 2, 0);
    add(1, 1, 4'hB, 8'h57, 0, 1, 0, 0);
    add(1, 0, 4'h0, 8'h57, 1, 1, 0, 0);
    add(1, 0, 4'h0, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h5, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'h1, 8'h57, 0, 1, 2, 0);
    add(1, 1, 4'h9, 8'h57, 0, 1, 2, 1);
    add(1, 1, 4'hB, 8'h51, 0, 1, 0, 0);
    add(1, 0, 4'h0, 8'h51, 1, 1, 0, 0);
    add(1, 1, 4'h3, 8'h51, 0, 1, 1, 0);
    add(1, 1, 4'hA, 8'h51, 0, 1, 0, 0);
    add(1, 1, 4'h5, 8'h51, 0, 1, 1, 0);
    add(1, 1, 4'h7, 8'h51, 0, 1, 2, 0);
    add(1, 1, 4'hB, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h4, 8'h57, 1, 1, 0, 0);
    add(1, 0, 4'h0, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h5, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'hB, 8'h57, 0, 1, 0, 1);
    add(1, 0, 4'h0, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h2, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'hE, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'hA, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h5, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'h7, 8'h57, 0, 1, 2, 0);
    add(0, 1, 4'hB, 8'h57, 0, 0, 0, 0);
    add(0, 0, 4'h0, 8'h57, 0, 0, 0, 0);
    add(0, 1, 4'h3, 8'h57, 0, 0, 0, 0);
    add(1, 0, 4'h0, 8'h57, 0, 1, 0, 0);
    add(1, 1, 4'h9, 8'h57, 0, 1, 1, 0);
    add(1, 1, 4'h8, 8'h57, 0, 1, 2, 0);
    add(1, 1, 4'hB, 8'h98, 0, 1, 0, 0);
    add(0, 0, 4'h0, 8'h98, 1, 0, 0, 0);
    add(0, 0, 4'h0, 8'h98, 0, 0, 0, 0);

    step();
    step();
    check("reset", 8'h00, 0, 0, 0, 0);
    rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].s, vq[i].kv, vq[i].code);
      step();
      check($sformatf("vec%0d", i), vq[i].pw, vq[i].tr, vq[i].busy,
            vq[i].cnt, vq[i].err);
    end

    // Inactivity timeout: 63 idle cycles keep the digit, the 64th drops it.
    drive(1, 0, 4'h0);
    step();
    drive(1, 1, 4'h5);
    step();
    check("to_key", 8'h98, 0, 1, 1, 0);
    drive(1, 0, 4'h0);
    for (int n = 0; n < 63; n++) step();
    check("to_63", 8'h98, 0, 1, 1, 0);
    step();
    check("to_64", 8'h98, 0, 1, 0, 0);
    drive(1, 1, 4'h7);
    step();
    step();
    check("to_77", 8'h98, 0, 1, 2, 0);
    drive(1, 1, 4'hB);
    step();
    check("to_ent", 8'h77, 0, 1, 0, 0);
    drive(1, 0, 4'h0);
    step();
    check("to_try", 8'h77, 1, 1, 0, 0);

    // Async reset while the submit strobe is high.
    step();
    drive(1, 1, 4'h1);
    step();
    drive(1, 1, 4'h2);
    step();
    drive(1, 1, 4'hB);
    step();
    check("rs_ent", 8'h12, 0, 1, 0, 0);
    drive(1, 0, 4'h0);
    step();
    check("rs_try", 8'h12, 1, 1, 0, 0);
    #3 rst = 1'b0;
    #1 check("rs_async", 8'h00, 0, 0, 0, 0);
    step();
    check("rs_hold", 8'h00, 0, 0, 0, 0);
    drive(1, 1, 4'h5);
    rst = 1'b1;
    step();
    check("rs_idle", 8'h00, 0, 1, 0, 0);
    drive(1, 1, 4'h3);
    step();
    check("rs_dig", 8'h00, 0, 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
